// File: rtl/std_multi_counter_if.sv
// ============================================================================
// Module   : std_multi_counter_if
// Brief    : Per-channel control/status bundle for std_multi_counter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface std_multi_counter_if #(
    parameter int CHANNELS   = 4,
    parameter int WIDTH      = 8,
    parameter int STEP_WIDTH = 4
);
    logic [CHANNELS-1:0]            i_clear;
    logic [CHANNELS-1:0]            i_set;
    logic [CHANNELS*WIDTH-1:0]      i_set_value;
    logic [CHANNELS-1:0]            i_up;
    logic [CHANNELS-1:0]            i_down;
    logic [CHANNELS*STEP_WIDTH-1:0] i_step;
    logic [CHANNELS-1:0]            i_flag_clear;
    logic [CHANNELS*WIDTH-1:0]      o_count;
    logic [CHANNELS*WIDTH-1:0]      o_count_next;
    logic [CHANNELS-1:0]            o_wrap_around;
    logic [CHANNELS-1:0]            o_bound_flag;

    modport master (
        output i_clear, i_set, i_set_value, i_up, i_down, i_step, i_flag_clear,
        input  o_count, o_count_next, o_wrap_around, o_bound_flag
    );

    modport slave (
        input  i_clear, i_set, i_set_value, i_up, i_down, i_step, i_flag_clear,
        output o_count, o_count_next, o_wrap_around, o_bound_flag
    );
endinterface

`default_nettype wire

// File: rtl/std_multi_counter.sv
// ============================================================================
// Module   : std_multi_counter
// Brief    : Bank of up/down step counters with wrap or saturate at bounds and
//            sticky bound flags. Define STD_MULTI_COUNTER_CASCADE_EN to ripple
//            channel k-1 bound events into channel k as a unit step.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module std_multi_counter #(
    parameter int                CHANNELS      = 4,
    parameter int                WIDTH         = 8,
    parameter int                STEP_WIDTH    = 4,
    parameter logic [WIDTH-1:0]  MAX_COUNT     = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0]  MIN_COUNT     = '0,
    parameter logic [WIDTH-1:0]  INITIAL_COUNT = MIN_COUNT,
    parameter bit                WRAP_AROUND   = 1'b1
) (
    input  wire                  i_clk,
    input  wire                  i_rst,
    std_multi_counter_if.slave   bus
);
    // Extended width so count+step never truncates before the bound compare.
    localparam int EW = WIDTH + STEP_WIDTH + 1;
    localparam logic [EW-1:0]        MAX_EXT  = EW'(MAX_COUNT);
    localparam logic signed [EW-1:0] MIN_SEXT = EW'(MIN_COUNT);
    localparam logic [EW-1:0]        SPAN_EXT = EW'(MAX_COUNT) - EW'(MIN_COUNT) + EW'(1);

    logic [WIDTH-1:0]      count_reg [CHANNELS];
    logic [WIDTH-1:0]      count_nxt [CHANNELS];
    logic [CHANNELS-1:0]   wrap_evt;
    logic [CHANNELS-1:0]   flag_reg;

    logic                  carry_up;
    logic                  carry_dn;
    logic                  eff_up;
    logic                  eff_dn;
    logic [STEP_WIDTH-1:0] eff_step;
    logic [EW-1:0]         sum;
    logic signed [EW-1:0]  diff;

    // Single sequential loop so the cascade ripple is evaluated in channel order.
    always_comb begin
        carry_up = 1'b0;
        carry_dn = 1'b0;
        eff_up   = 1'b0;
        eff_dn   = 1'b0;
        eff_step = '0;
        sum      = '0;
        diff     = '0;
        wrap_evt = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            eff_up   = bus.i_up[k];
            eff_dn   = bus.i_down[k];
            eff_step = bus.i_step[k*STEP_WIDTH +: STEP_WIDTH];
`ifdef STD_MULTI_COUNTER_CASCADE_EN
            if (k > 0 && (carry_up || carry_dn)) begin
                eff_up   = carry_up;
                eff_dn   = carry_dn;
                eff_step = STEP_WIDTH'(1);
            end
`endif
            sum       = EW'(count_reg[k]) + EW'(eff_step);
            diff      = $signed(EW'(count_reg[k])) - $signed(EW'(eff_step));
            carry_up  = 1'b0;
            carry_dn  = 1'b0;
            count_nxt[k] = count_reg[k];
            if (bus.i_clear[k]) begin
                count_nxt[k] = INITIAL_COUNT;
            end else if (bus.i_set[k]) begin
                count_nxt[k] = bus.i_set_value[k*WIDTH +: WIDTH];
            end else if (eff_up && !eff_dn && eff_step != '0) begin
                if (sum > MAX_EXT) begin
                    carry_up     = 1'b1;
                    count_nxt[k] = WRAP_AROUND ? WIDTH'(sum - SPAN_EXT) : MAX_COUNT;
                end else begin
                    count_nxt[k] = WIDTH'(sum);
                end
            end else if (eff_dn && !eff_up && eff_step != '0) begin
                if (diff < MIN_SEXT) begin
                    carry_dn     = 1'b1;
                    count_nxt[k] = WRAP_AROUND ? WIDTH'(diff + $signed(SPAN_EXT)) : MIN_COUNT;
                end else begin
                    count_nxt[k] = WIDTH'(diff);
                end
            end
            wrap_evt[k] = carry_up | carry_dn;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int k = 0; k < CHANNELS; k++) count_reg[k] <= INITIAL_COUNT;
            flag_reg <= '0;
        end else begin
            for (int k = 0; k < CHANNELS; k++) count_reg[k] <= count_nxt[k];
            flag_reg <= wrap_evt | (flag_reg & ~bus.i_flag_clear);
        end
    end

    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_out
            assign bus.o_count[g*WIDTH +: WIDTH]      = count_reg[g];
            assign bus.o_count_next[g*WIDTH +: WIDTH] = count_nxt[g];
        end
    endgenerate

    assign bus.o_wrap_around = wrap_evt;
    assign bus.o_bound_flag  = flag_reg;

`ifndef SYNTHESIS
    generate
        for (genvar g = 0; g < CHANNELS; g++) begin : g_chk
            a_step_range : assert property (@(posedge i_clk) disable iff (!i_rst)
                (!bus.i_clear[g] && !bus.i_set[g] && (bus.i_up[g] ^ bus.i_down[g]))
                |-> (EW'(bus.i_step[g*STEP_WIDTH +: STEP_WIDTH]) <= SPAN_EXT));
        end
    endgenerate
`endif

endmodule

`default_nettype wire
